spi_slave_responder: RTL
========================

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 Parameter TX_DEPTH, default 4, is the TX FIFO depth in bytes and SHALL be a power of two, 2 to 16.
REQ-002 Parameter IDLE_BYTE, default 8'hFF, is the byte shifted out when the TX FIFO is empty.
REQ-003 clk50mhz  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI clock from master, asynchronous, mode 0 (CPOL=0, CPHA=0).
REQ-006 cs  input  1  SPI chip select from master, asynchronous, active-low.
REQ-007 mosi  input  1  SPI data from master, asynchronous, MSB first.
REQ-008 miso  output  1  SPI data to master, MSB first.
REQ-009 tx_data  input  8  byte to queue for transmission.
REQ-010 tx_valid  input  1  tx_data valid; byte accepted when tx_valid and tx_ready are both 1.
REQ-011 tx_ready  output  1  TX FIFO not full.
REQ-012 rx_data  output  8  last complete byte received on mosi.
REQ-013 rx_valid  output  1  one-cycle pulse; rx_data is new.
REQ-014 busy  output  1  cs asserted (synchronised) and transfer in progress.
REQ-015 underrun  output  1  one-cycle pulse; IDLE_BYTE substituted because the FIFO was empty.

Function
REQ-016 sclk, cs and mosi SHALL each pass through a 2-flop synchroniser; sclk and cs SHALL have a third stage for edge detection.
REQ-017 The supported sclk frequency SHALL be at most clk50mhz/8; behaviour above this is undefined.
REQ-018 States: IDLE, ACTIVE. IDLE->ACTIVE on a synchronised cs falling edge; ACTIVE->IDLE on a synchronised cs rising edge.
REQ-019 On IDLE->ACTIVE: bit_cnt=0; tx shift register loaded from the FIFO head (pop) if not empty, else IDLE_BYTE with an underrun pulse.
REQ-020 miso SHALL equal tx_shift[7] in ACTIVE and 1 in IDLE.
REQ-021 Synchronised sclk rising edge in ACTIVE: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt increments mod 8.
REQ-022 On the 8th rising edge: rx_data <= {rx_shift[6:0], mosi_s}, and rx_valid pulses 1 on the next cycle; there is no backpressure on rx.
REQ-023 Synchronised sclk falling edge in ACTIVE with bit_cnt != 0: tx_shift <= {tx_shift[6:0], 1'b0}.
REQ-024 Synchronised sclk falling edge in ACTIVE with bit_cnt == 0 (byte boundary, after at least one byte): load the next tx byte per REQ-019.
REQ-025 cs deassert mid-byte: the partial rx byte SHALL be discarded (no rx_valid); the partial tx byte SHALL be lost (not re-queued); go to IDLE.
REQ-026 sclk edges while in IDLE SHALL be ignored.
REQ-027 TX FIFO: synchronous, TX_DEPTH entries, binary pointers one bit wider than the address; tx_ready = !full.
REQ-028 Push and pop in the same cycle SHALL both take effect.
REQ-029 A pop with the FIFO empty SHALL yield IDLE_BYTE; a same-cycle push is still stored.
REQ-030 Pointers wrap modulo 2*TX_DEPTH; no data loss on wrap.
REQ-031 busy = (state == ACTIVE).

Reset
REQ-032 While rst=1: state=IDLE, FIFO empty, tx_ready=1, miso=1, rx_data=8'h00, rx_valid=0, underrun=0, busy=0, shift registers=0, bit_cnt=0, synchroniser flops=idle levels (cs=1, sclk=0).
REQ-033 rst asserted mid-transfer SHALL abort without rx_valid; cs must see a fresh falling edge after reset before ACTIVE is entered.

Verification
REQ-034 Push 8'hA5, 8'h3C; master sends 8'h5A, 8'hC3 in one cs frame at clk/8 -> miso carries A5,3C; rx_valid twice with rx_data 5A then C3.
REQ-035 Empty FIFO; master transfers one byte 8'h81 -> miso=8'hFF, underrun pulses once, rx_data=8'h81.
REQ-036 Push 4 bytes (TX_DEPTH=4) -> tx_ready=0; a 5th push is ignored; master reads 5 bytes -> the 4 bytes in order, then FF plus underrun.
REQ-037 cs deasserted after 5 sclk cycles -> no rx_valid, busy falls, miso=1; the next frame receives the next FIFO byte.
REQ-038 rst pulsed during bit 3 of a transfer -> all outputs match REQ-032; the FIFO is empty after rst.
REQ-039 tx_valid held while the master pops at full -> push and pop in the same cycle, level unchanged, order preserved.

Source files
------------

// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
// SPI mode-0 slave: shifts queued TX bytes out on miso and delivers received mosi bytes.
// Latency: pins cross a 2-flop synchroniser; rx_valid follows the 8th sclk rise by ~4 clocks.
// Backpressure: tx_ready drops when the TX FIFO is full; rx has none (rx_valid is a pulse).
module spi_slave_responder #(
  parameter int         TX_DEPTH  = 4,
  parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       underrun
);

  localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // ------------------------------------------------------------------
  // Pin synchronisers
  // ------------------------------------------------------------------
  logic       sclk_s1, sclk_s2, sclk_s3;
  logic       cs_s1, cs_s2, cs_s3;
  logic       mosi_s1, mosi_s2;
  logic [1:0] sync_fill;
  logic       sync_ok;
  logic       sclk_rise, sclk_fall;
  logic       cs_fall, cs_rise;

  // Two stages for metastability, a third on sclk/cs for edge detection.
  // sync_fill counts post-reset cycles so the idle levels forced by reset
  // are never mistaken for a real cs falling edge.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_s3   <= 1'b0;
      cs_s1     <= 1'b1;
      cs_s2     <= 1'b1;
      cs_s3     <= 1'b1;
      mosi_s1   <= 1'b0;
      mosi_s2   <= 1'b0;
      sync_fill <= 2'd0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      if (sync_fill != 2'd3) begin
        sync_fill <= sync_fill + 2'd1;
      end
    end
  end

  // Edges are only trusted once every stage holds a real pin sample.
  assign sync_ok   = (sync_fill == 2'd3);
  assign sclk_rise = sync_ok &  sclk_s2 & ~sclk_s3;
  assign sclk_fall = sync_ok & ~sclk_s2 &  sclk_s3;
  assign cs_fall   = sync_ok & ~cs_s2   &  cs_s3;
  assign cs_rise   = sync_ok &  cs_s2   & ~cs_s3;

  // ------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_empty;
  logic        push, pop;
  logic [7:0]  load_byte;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = ~fifo_full;
  assign push       = tx_valid & ~fifo_full;

  // An empty FIFO hands out IDLE_BYTE; the pop is then a no-op on the pointers.
  assign load_byte  = fifo_empty ? IDLE_BYTE : fifo_mem[rd_ptr[AW-1:0]];

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge clk50mhz) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
    end
  end

  // Pointers carry an extra wrap bit to tell full from empty.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Transfer FSM
  // ------------------------------------------------------------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic       rx_pend;
  logic       byte_done;
  logic       load_tx;

  // A TX load happens at frame start and on the falling edge that closes a
  // completed byte; cs rising takes priority over any sclk activity.
  always_comb begin
    load_tx = 1'b0;
    if (state == IDLE) begin
      load_tx = cs_fall;
    end else if (!cs_rise && sclk_fall && (bit_cnt == 3'd0) && byte_done) begin
      load_tx = 1'b1;
    end
  end

  assign pop = load_tx & ~fifo_empty;

  // Frame state, shift registers and the registered rx/underrun outputs.
  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      rx_data   <= 8'h00;
      rx_pend   <= 1'b0;
      rx_valid  <= 1'b0;
      underrun  <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      rx_valid <= rx_pend;
      rx_pend  <= 1'b0;
      underrun <= load_tx & fifo_empty;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= ACTIVE;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            tx_shift  <= load_byte;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Any partial byte in either direction is simply dropped.
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s2};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data   <= {rx_shift[6:0], mosi_s2};
              rx_pend   <= 1'b1;
              byte_done <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end else if (byte_done) begin
              tx_shift  <= load_byte;
              byte_done <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign miso = (state == ACTIVE) ? tx_shift[7] : 1'b1;
  assign busy = (state == ACTIVE);

endmodule
